axi_slave_read_control: RTL and testbench

AXI3/AXI4 read-channel slave responder: accepts one AR transaction at a time, generates FIXED/INCR/WRAP beat addresses, reads a synchronous single-port memory, and returns the data on the R channel with RLAST and RRESP. It is the slave-side counterpart of the master read control block and terminates the read path in front of the FIFO/memory model in the AXI FIFO BFM.

---
 rtl/axi_slave_read_control.sv | 134 +++++++++++++
 tb/tb_axi_slave_read_control.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_read_control.sv
// axi_slave_read_control: AXI3/AXI4 read-channel slave that serves one AR burst at a time from a synchronous memory.
// Ports: AClk/ARst (clock, async active-low reset); AR channel ARID..ARVALID in, ARREADY out;
// R channel RID/RDATA/RRESP/RLAST/RVALID out, RREADY in; memory port mem_rd_en/mem_addr out, mem_rdata in.
// Optional macro AXI_SLV_RD_DECERR_EN: beats whose word address is >= mem_words return DECERR.
module axi_slave_read_control #(
  parameter int addr_width = 32,
  parameter int data_width = 64,
  parameter int mem_words = 1024
) (
  input  logic                  AClk,
  input  logic                  ARst,
  input  logic [7:0]            ARID,
  input  logic [addr_width-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [1:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [7:0]            RID,
  output logic [data_width-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_rd_en,
  output logic [addr_width-1:0] mem_addr,
  input  logic [data_width-1:0] mem_rdata
);
  localparam int LNB = $clog2(data_width / 8);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  state_t state_q;
  logic [addr_width-1:0] addr_q, addr_d, mem_addr_q, s, w, base, amask;
  logic [data_width-1:0] rdata_q;
  logic [7:0] rid_q, len_q, beat_q;
  logic [2:0] size_q;
  logic [1:0] burst_q, rresp_q;
  logic slverr_q, arready_q, rvalid_q, rlast_q, rd_en_q;
  logic ar_err, dec_ar, dec_cur, dec_next, unused;
  assign unused = ^{ARLOCK, ARCACHE, ARPROT};
  assign amask = (addr_width'(1) << ARSIZE) - addr_width'(1);
  assign ar_err = ARBURST == 2'b11 || int'(ARSIZE) > LNB ||
                  (ARBURST == 2'b10 && !(ARLEN == 8'd1 || ARLEN == 8'd3 || ARLEN == 8'd7 || ARLEN == 8'd15)) ||
                  (ARBURST == 2'b10 && (ARADDR & amask) != '0);
`ifdef AXI_SLV_RD_DECERR_EN
  assign dec_ar   = (ARADDR >> LNB) >= addr_width'(mem_words);
  assign dec_cur  = (addr_q >> LNB) >= addr_width'(mem_words);
  assign dec_next = (addr_d >> LNB) >= addr_width'(mem_words);
`else
  assign dec_ar   = 1'b0;
  assign dec_cur  = 1'b0;
  assign dec_next = 1'b0;
`endif
  // WRAP masking relies on the window being a power of two; illegal WRAP lengths are error beats anyway.
  always_comb begin
    s = addr_width'(1) << size_q;
    w = s * addr_width'({1'b0, len_q} + 9'd1);
    base = addr_q & ~(w - addr_width'(1));
    addr_d = burst_q == 2'b00 ? addr_q :
             burst_q == 2'b10 ? base + ((addr_q + s - base) & (w - addr_width'(1))) :
             (addr_q & ~(s - addr_width'(1))) + s;
  end
  always_ff @(posedge AClk or negedge ARst)
    if (!ARst) begin
      state_q <= IDLE;
      arready_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      rid_q <= '0;
      rd_en_q <= 1'b0;
      mem_addr_q <= '0;
      addr_q <= '0;
      len_q <= '0;
      size_q <= '0;
      burst_q <= '0;
      beat_q <= '0;
      slverr_q <= 1'b0;
    end else
      case (state_q)
        IDLE:
          if (arready_q && ARVALID) begin
            arready_q <= 1'b0;
            rid_q <= ARID;
            addr_q <= ARADDR;
            len_q <= ARLEN;
            size_q <= ARSIZE;
            burst_q <= ARBURST;
            beat_q <= '0;
            slverr_q <= ar_err;
            rd_en_q <= !(ar_err || dec_ar);
            mem_addr_q <= ARADDR >> LNB;
            state_q <= ISSUE;
          end else
            arready_q <= 1'b1;
        ISSUE: begin
          rd_en_q <= 1'b0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          rdata_q <= (slverr_q || dec_cur) ? '0 : mem_rdata;
          rresp_q <= slverr_q ? 2'b10 : dec_cur ? 2'b11 : 2'b00;
          rlast_q <= beat_q == len_q;
          rvalid_q <= 1'b1;
          state_q <= RESP;
        end
        RESP:
          if (RREADY) begin
            rvalid_q <= 1'b0;
            rlast_q <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              addr_q <= addr_d;
              beat_q <= beat_q + 8'd1;
              rd_en_q <= !(slverr_q || dec_next);
              mem_addr_q <= addr_d >> LNB;
              state_q <= ISSUE;
            end
          end
      endcase
  assign ARREADY = arready_q;
  assign RID = rid_q;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign RLAST = rlast_q;
  assign RVALID = rvalid_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr = mem_addr_q;
endmodule

// File: tb/tb_axi_slave_read_control.sv
// tb_axi_slave_read_control: scoreboard bench for axi_slave_read_control.
module tb_axi_slave_read_control;
`ifdef AXI_SLV_RD_DECERR_EN
  localparam int MW = 16;
`else
  localparam int MW = 1024;
`endif
  typedef struct packed {logic [7:0] id; logic [63:0] data; logic [1:0] resp; logic last;} beat_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] ARID = '0, ARLEN = '0, RID;
  logic [31:0] ARADDR = '0, mem_addr, mon_a;
  logic [2:0] ARSIZE = '0, ARPROT = '0;
  logic [1:0] ARBURST = '0, ARLOCK = '0, ARCACHE = '0, RRESP;
  logic ARVALID = 1'b0, ARREADY, RLAST, RVALID, RREADY = 1'b0, mem_rd_en;
  logic [63:0] RDATA, mem_rdata;
  beat_t exp_q[$];
  logic [31:0] rd_q[$];
  int checks = 0, passed = 0, rd_cnt = 0;
  time e0_t, first_rv_t, last_hs_t;
  axi_slave_read_control #(.addr_width(32), .data_width(64), .mem_words(MW)) dut (
    .AClk(clk), .ARst(rst_n), .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID),
    .ARREADY(ARREADY), .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata));
  always #5 clk = ~clk;
  function automatic logic [63:0] mdata(input logic [31:0] wd);
    return {wd ^ 32'hC0DE0000, ~wd};
  endfunction
  always @(posedge clk) mem_rdata <= mem_rd_en ? mdata(mem_addr) : 64'hBAD0BAD0BAD0BAD0;
  always @(negedge clk)
    if (rst_n && mem_rd_en) begin
      rd_cnt++;
      checks++;
      if (rd_q.size() == 0) $display("FAIL rd_unexpected mem_addr=%h expected no read", mem_addr);
      else begin
        mon_a = rd_q.pop_front();
        if (mem_addr !== mon_a) $display("FAIL rd_addr got %h expected %h", mem_addr, mon_a);
        else passed++;
      end
    end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  task automatic push_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a, s, w, base, wd;
    logic slv, dec;
    logic [1:0] resp;
    a = addr;
    s = 32'd1 << size;
    w = s * (32'(len) + 32'd1);
    slv = burst == 2'b11 || size > 3'd3 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) ||
          (burst == 2'b10 && a % s != 0);
    for (int i = 0; i <= int'(len); i++) begin
      wd = a >> 3;
`ifdef AXI_SLV_RD_DECERR_EN
      dec = wd >= 32'(MW);
`else
      dec = 1'b0;
`endif
      resp = slv ? 2'b10 : dec ? 2'b11 : 2'b00;
      exp_q.push_back({id, resp == 2'b00 ? mdata(wd) : 64'd0, resp, i == int'(len)});
      if (resp == 2'b00) rd_q.push_back(wd);
      base = a / w * w;
      a = burst == 2'b00 ? a : burst == 2'b10 ? base + (a + s - base) % w : a / s * s + s;
    end
  endtask
  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k;
    push_burst(id, addr, len, size, burst);
    {ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID} = {id, addr, len, size, burst, 1'b1};
    k = 0;
    while (!ARREADY && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!ARREADY) $display("FAIL arready_timeout got 0 expected 1");
    else passed++;
    @(posedge clk);
    e0_t = $time;
    @(negedge clk);
    ARVALID = 1'b0;
  endtask
  task automatic drain(input int n, input logic [15:0] stall_pat);
    for (int b = 0; b < n; b++) begin
      beat_t e;
      logic [75:0] snap;
      int k, rc;
      k = 0;
      while (!RVALID && k < 20) begin
        @(negedge clk);
        k++;
      end
      e = exp_q.pop_front();
      checks++;
      if (!RVALID) begin
        $display("FAIL rvalid_timeout beat %0d got 0 expected 1", b);
        return;
      end
      passed++;
      if (b == 0) first_rv_t = $time;
      checks++;
      if ({RID, RDATA, RRESP, RLAST} !== e)
        $display("FAIL rbeat %0d got id=%h data=%h resp=%b last=%b expected id=%h data=%h resp=%b last=%b",
                 b, RID, RDATA, RRESP, RLAST, e.id, e.data, e.resp, e.last);
      else passed++;
      if (stall_pat[b]) begin
        snap = {RID, RDATA, RRESP, RLAST, RVALID};
        rc = rd_cnt;
        repeat (2) @(negedge clk);
        checks++;
        if ({RID, RDATA, RRESP, RLAST, RVALID} !== snap || rd_cnt != rc)
          $display("FAIL stall_hold beat %0d got %h reads=%0d expected %h reads=%0d", b,
                   {RID, RDATA, RRESP, RLAST, RVALID}, rd_cnt, snap, rc);
        else passed++;
      end
      RREADY = 1'b1;
      @(posedge clk);
      last_hs_t = $time;
      @(negedge clk);
      RREADY = 1'b0;
    end
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ARREADY, RVALID, RLAST, RDATA, RRESP, RID, mem_rd_en, mem_addr} !== '0)
      $display("FAIL reset_values got %h expected 0", {ARREADY, RVALID, RLAST, RDATA, RRESP, RID, mem_rd_en, mem_addr});
    else passed++;
    rst_n = 1'b1;
    #1;
    checks++;
    if (ARREADY !== 1'b0) $display("FAIL arready_on_release got %b expected 0", ARREADY);
    else passed++;
    @(negedge clk);
    checks++;
    if (ARREADY !== 1'b1) $display("FAIL arready_after_edge got %b expected 1", ARREADY);
    else passed++;
  endtask
  task automatic test_single;
    send_ar(8'h05, 32'h40, 8'd0, 3'd3, 2'b01);
    checks++;
    if (mem_rd_en !== 1'b1 || ARREADY !== 1'b0)
      $display("FAIL single_issue got rd_en=%b arready=%b expected 1 0", mem_rd_en, ARREADY);
    else passed++;
    drain(1, 16'h0);
    checks++;
    if (first_rv_t - e0_t != 25) $display("FAIL single_rvalid_latency got %0t expected 25", first_rv_t - e0_t);
    else passed++;
    checks++;
    if (last_hs_t - e0_t != 30 || ARREADY !== 1'b1)
      $display("FAIL single_done got %0t arready=%b expected 30 1", last_hs_t - e0_t, ARREADY);
    else passed++;
  endtask
  task automatic test_incr4;
    send_ar(8'h11, 32'h100, 8'd3, 3'd3, 2'b01);
    {ARID, ARADDR, ARVALID} = {8'hEE, 32'h0, 1'b1};
    drain(4, 16'h0);
    ARVALID = 1'b0;
    checks++;
    if (last_hs_t - e0_t != 120 || ARREADY !== 1'b1)
      $display("FAIL incr4_done got %0t arready=%b expected 120 1", last_hs_t - e0_t, ARREADY);
    else passed++;
  endtask
  task automatic test_wrap;
    send_ar(8'h22, 32'h30, 8'd3, 3'd3, 2'b10);
    drain(4, 16'h0);
    send_ar(8'h23, 32'h30, 8'd2, 3'd3, 2'b10);
    drain(3, 16'h0);
    send_ar(8'h24, 32'h34, 8'd3, 3'd3, 2'b10);
    drain(4, 16'h0);
    checks++;
    if (rd_q.size() != 0) $display("FAIL wrap_reads got %0d pending expected 0", rd_q.size());
    else passed++;
  endtask
  task automatic test_fixed_stall;
    send_ar(8'h33, 32'h18, 8'd7, 3'd3, 2'b00);
    drain(8, 16'b0110_0110);
    checks++;
    if (exp_q.size() != 0 || rd_q.size() != 0 || ARREADY !== 1'b1)
      $display("FAIL fixed_done got exp=%0d rd=%0d arready=%b expected 0 0 1", exp_q.size(), rd_q.size(), ARREADY);
    else passed++;
  endtask
  task automatic test_errors;
    send_ar(8'h44, 32'h80, 8'd1, 3'd3, 2'b11);
    drain(2, 16'h0);
    send_ar(8'h45, 32'h80, 8'd0, 3'd4, 2'b01);
    drain(1, 16'h0);
    checks++;
    if (rd_q.size() != 0) $display("FAIL error_reads got %0d pending expected 0", rd_q.size());
    else passed++;
  endtask
  task automatic test_back_to_back;
    send_ar(8'h56, 32'h78, 8'd1, 3'd3, 2'b01);
    drain(2, 16'h0);
    send_ar(8'h57, 32'h104, 8'd3, 3'd2, 2'b01);
    drain(4, 16'h0);
    send_ar(8'h58, 32'h103, 8'd1, 3'd3, 2'b01);
    drain(2, 16'h0);
    send_ar(8'h59, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01);
    drain(2, 16'h0);
    checks++;
    if (rd_q.size() != 0 || exp_q.size() != 0)
      $display("FAIL b2b_pending got rd=%0d exp=%0d expected 0 0", rd_q.size(), exp_q.size());
    else passed++;
  endtask
  task automatic test_reset_mid;
    int k;
    send_ar(8'h3C, 32'h200, 8'd3, 3'd3, 2'b01);
    drain(1, 16'h0);
    k = 0;
    while (!RVALID && k < 10) begin
      @(negedge clk);
      k++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({RVALID, RLAST, ARREADY, RDATA, RID} !== '0)
      $display("FAIL reset_mid got rvalid=%b rlast=%b arready=%b expected 0 0 0", RVALID, RLAST, ARREADY);
    else passed++;
    exp_q.delete();
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_ar(8'h7E, 32'h48, 8'd1, 3'd3, 2'b01);
    drain(2, 16'h0);
    checks++;
    if (rd_q.size() != 0 || ARREADY !== 1'b1)
      $display("FAIL reset_recover got rd=%0d arready=%b expected 0 1", rd_q.size(), ARREADY);
    else passed++;
  endtask
  initial begin
    test_reset;
    test_single;
    test_incr4;
    test_wrap;
    test_fixed_stall;
    test_errors;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
